barrido_display: RTL and testbench
==================================

Name: barrido_display

Overview:
- Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
- Owns the shared nibble-to-segment decoder. Each slot it drives one digit's nibble onto the decoder input and enables that digit's anode.
- Double-buffers the displayed value so updates land only on frame boundaries (no tearing).
- Adds per-digit enables, optional leading-zero suppression and an inter-digit blanking interval against ghosting.

Parameters:
- N_DIG, 8, number of digits scanned (>=2)
- PRESC, 100000, clock cycles per digit slot
- BLANK, 1000, cycles at the start of each slot with all anodes off (0 <= BLANK < PRESC)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valor  input  4*N_DIG  value to display; nibble i (bits 4i+3:4i) goes to digit i, digit 0 rightmost
- actualizar  input  1  single-cycle strobe; samples valor into the shadow register
- habil  input  N_DIG  per-digit enable; 0 keeps that digit dark
- supr_ceros  input  1  1 enables leading-zero suppression
- numero  output  4  nibble for the segment decoder
- an  output  N_DIG  anode enables, active low, at most one bit low
- blank  output  1  1 when no anode is low; downstream forces segments off
- fin_barrido  output  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset (async, immediate): cnt=0, idx=0, shadow=0, active=0, pending=0, numero=0, an=all ones, blank=1, fin_barrido=0.
- cnt counts 0..PRESC-1 and wraps. On wrap, idx increments 0..N_DIG-1 and wraps to 0. Frame length = N_DIG*PRESC cycles.
- All outputs are registered and reflect the current (cnt, idx):
  - numero = active nibble idx for the entire slot, including the blank phase, so the decoder settles.
  - If cnt < BLANK: an = all ones, blank = 1.
  - If cnt >= BLANK and digit idx is visible: an[idx] = 0, other bits 1, blank = 0.
  - If cnt >= BLANK and digit idx is not visible: an = all ones, blank = 1.
- Visible(i) = habil[i] AND NOT suppressed(i).
- suppressed(i) = supr_ceros AND i != 0 AND active nibbles N_DIG-1 down to i are all zero. Digit 0 is never suppressed.
- Suppression and habil are evaluated live from the active register and inputs. They are not buffered.
- actualizar: shadow <= valor, pending <= 1.
- Frame end (edge where cnt=PRESC-1 and idx=N_DIG-1):
  - fin_barrido pulses for the following cycle.
  - If pending: active <= shadow, pending <= 0.
  - If actualizar is high on that same edge: active <= valor directly, shadow <= valor, pending <= 0. The new value is shown from slot 0 of the next frame.
- Multiple actualizar strobes within one frame: last one wins.
- Reset mid-frame discards the shadow and pending state. The display restarts at digit 0 showing 0.

Test Plan:
(Bench uses N_DIG=4, PRESC=8, BLANK=2.)
- Reset: assert rst_n low at cycle 13, mid-slot -> an=1111, blank=1, numero=0, fin_barrido=0 in the same cycle, before any clock edge. After release, idx=0 and cnt=0.
- Basic scan: valor=0x1234, actualizar pulse, habil=1111, supr_ceros=0 -> after the next frame end:
  - slot0: numero=4; an=1111 for cycles 0-1, an=1110 for cycles 2-7.
  - slots 1, 2, 3: numero=3/2/1 with an=1101/1011/0111 respectively.
  - fin_barrido pulses every 32 cycles.
- Tearing: while displaying 0x1234, pulse actualizar with 0xABCD at slot 1 -> slots 1-3 still show 3,2,1. Slot 0 of the next frame shows D.
- Leading zeros, supr_ceros=1:
  - valor=0x0050 -> digits 3 and 2 dark (an=1111, blank=1); digit 1 shows 5; digit 0 shows 0.
  - valor=0x0000 -> only digit 0 lit, showing 0.
- Enables: habil=1010, valor=0x1234 -> slots 0 and 2 have an=1111 and blank=1 for the full slot; slots 1 and 3 show 3 and 1.
- Simultaneous: actualizar with valor=0x5678 on the frame-end edge while pending holds 0x9999 -> the next frame shows 8,7,6,5 and pending is cleared.

Source files
------------

// File: rtl/barrido_display.sv
// Multiplexed scan controller for an N-digit common-anode 7-segment display.
// Frame-synchronous double buffering, per-digit enables, leading-zero blanking.
module barrido_display #(
    parameter int N_DIG = 8,
    parameter int PRESC = 100000,
    parameter int BLANK = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*N_DIG-1:0] valor,
    input  logic               actualizar,
    input  logic [N_DIG-1:0]   habil,
    input  logic               supr_ceros,
    output logic [3:0]         numero,
    output logic [N_DIG-1:0]   an,
    output logic               blank,
    output logic               fin_barrido
);

    localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int IW = $clog2(N_DIG);
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESC - 1);
    localparam logic [CW-1:0] CNT_BLK = CW'(BLANK);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIG - 1);

    logic [CW-1:0]      r_cnt;
    logic [IW-1:0]      r_idx;
    logic [4*N_DIG-1:0] r_shadow;
    logic [4*N_DIG-1:0] r_active;
    logic               r_pending;
    logic [3:0]         r_numero;
    logic [N_DIG-1:0]   r_an;
    logic               r_blank;
    logic               r_fin;

    logic               w_cnt_end;
    logic               w_frame_end;
    logic [CW-1:0]      w_cnt_nx;
    logic [IW-1:0]      w_idx_nx;
    logic [4*N_DIG-1:0] w_act_nx;
    logic [N_DIG-1:0]   w_lead;
    logic [N_DIG-1:0]   w_vis;
    logic [N_DIG-1:0]   w_an;
    logic [3:0]         w_num;

    // Outputs are computed from next-state values so the registered outputs
    // always match the (cnt, idx) that is current after the edge.
    always_comb begin
        w_cnt_end   = (r_cnt == CNT_MAX);
        w_frame_end = w_cnt_end && (r_idx == IDX_MAX);
        w_cnt_nx    = w_cnt_end ? '0 : r_cnt + 1'b1;
        if (!w_cnt_end)
            w_idx_nx = r_idx;
        else if (w_frame_end)
            w_idx_nx = '0;
        else
            w_idx_nx = r_idx + 1'b1;

        w_act_nx = r_active;
        if (w_frame_end) begin
            if (actualizar)
                w_act_nx = valor;
            else if (r_pending)
                w_act_nx = r_shadow;
        end
    end

    // w_lead[i]: nibbles N_DIG-1 down to i of the displayed value are all zero
    always_comb begin
        w_lead[N_DIG-1] = (w_act_nx[4*(N_DIG-1) +: 4] == 4'd0);
        for (int i = N_DIG - 2; i >= 0; i--)
            w_lead[i] = w_lead[i+1] && (w_act_nx[4*i +: 4] == 4'd0);
    end

    always_comb begin
        w_vis = habil & ~({w_lead[N_DIG-1:1] & {(N_DIG-1){supr_ceros}}, 1'b0});
        w_num = w_act_nx[{w_idx_nx, 2'b00} +: 4];
        w_an  = '1;
        if ((w_cnt_nx >= CNT_BLK) && w_vis[w_idx_nx])
            w_an[w_idx_nx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= 1'b0;
            r_numero  <= 4'd0;
            r_an      <= '1;
            r_blank   <= 1'b1;
            r_fin     <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nx;
            r_idx    <= w_idx_nx;
            r_active <= w_act_nx;
            if (actualizar)
                r_shadow <= valor;
            // A frame end consumes the pending value, even if a strobe lands on it
            if (w_frame_end)
                r_pending <= 1'b0;
            else if (actualizar)
                r_pending <= 1'b1;
            r_numero <= w_num;
            r_an     <= w_an;
            r_blank  <= &w_an;
            r_fin    <= w_frame_end;
        end
    end

    assign numero      = r_numero;
    assign an          = r_an;
    assign blank       = r_blank;
    assign fin_barrido = r_fin;

endmodule

// File: tb/tb_barrido_display.sv
// Bench for barrido_display with N_DIG=4, PRESC=8, BLANK=2 (32-cycle frames).
// Per-frame expectations are queued at frame start and popped every cycle.
module tb_barrido_display;

    localparam int N_DIG = 4;
    localparam int PRESC = 8;
    localparam int BLANK = 2;
    localparam int FRAME = N_DIG * PRESC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] valor = '0;
    logic        actualizar = 1'b0;
    logic [3:0]  habil = 4'hF;
    logic        supr_ceros = 1'b0;
    logic [3:0]  numero;
    logic [3:0]  an;
    logic        blank;
    logic        fin_barrido;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] valor;
        logic [3:0]  habil;
        logic        supr;
        logic [15:0] num;   // nibble s = numero expected during slot s
        logic [15:0] anp;   // nibble s = anode pattern after the blank phase of slot s
    } vec_t;

    typedef struct {
        logic [3:0] num;
        logic [3:0] an;
        logic       blank;
        logic       fin;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    barrido_display #(.N_DIG(N_DIG), .PRESC(PRESC), .BLANK(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .valor(valor), .actualizar(actualizar),
        .habil(habil), .supr_ceros(supr_ceros), .numero(numero), .an(an),
        .blank(blank), .fin_barrido(fin_barrido)
    );

    always #5 clk = ~clk;

    task automatic check_out(input string name, input exp_t e);
        tests++;
        if (numero !== e.num || an !== e.an || blank !== e.blank || fin_barrido !== e.fin) begin
            fails++;
            $display("FAIL %s: got numero=%h an=%b blank=%b fin=%b, want numero=%h an=%b blank=%b fin=%b",
                     name, numero, an, blank, fin_barrido, e.num, e.an, e.blank, e.fin);
        end
    endtask

    // Called at the negedge of cycle 0 of a frame; leaves at cycle 0 of the next.
    task automatic check_frame(input string name, input logic [15:0] num, input logic [15:0] anp,
                               input logic fin0, input int ca, input logic [15:0] va,
                               input int cb, input logic [15:0] vb);
        exp_t e;
        for (int c = 0; c < FRAME; c++) begin
            e.num   = num[4*(c/PRESC) +: 4];
            e.an    = ((c % PRESC) < BLANK) ? 4'hF : anp[4*(c/PRESC) +: 4];
            e.blank = (e.an == 4'hF);
            e.fin   = (c == 0) ? fin0 : 1'b0;
            sb.push_back(e);
        end
        for (int c = 0; c < FRAME; c++) begin
            check_out($sformatf("%s c%0d", name, c), sb.pop_front());
            actualizar = (c == ca) || (c == cb);
            if (c == ca) valor = va;
            if (c == cb) valor = vb;
            @(negedge clk);
        end
        actualizar = 1'b0;
    endtask

    task automatic wait_fin(input string name);
        int n = 0;
        while (fin_barrido !== 1'b1 && n < FRAME + 8) begin
            @(negedge clk);
            n++;
        end
        if (fin_barrido !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s: fin_barrido=%b after %0d cycles, want 1", name, fin_barrido, n);
        end
    endtask

    task automatic pulse(input logic [15:0] v);
        valor = v;
        actualizar = 1'b1;
        @(negedge clk);
        actualizar = 1'b0;
    endtask

    initial begin
        exp_t rst_e;
        vecs[0] = '{valor: 16'h0050, habil: 4'hF, supr: 1'b1, num: 16'h0050, anp: 16'hFFDE};
        vecs[1] = '{valor: 16'h0000, habil: 4'hF, supr: 1'b1, num: 16'h0000, anp: 16'hFFFE};
        vecs[2] = '{valor: 16'h0900, habil: 4'hF, supr: 1'b1, num: 16'h0900, anp: 16'hFBDE};
        vecs[3] = '{valor: 16'h1234, habil: 4'hA, supr: 1'b0, num: 16'h1234, anp: 16'h7FDF};
        vecs[4] = '{valor: 16'hABCD, habil: 4'hF, supr: 1'b1, num: 16'hABCD, anp: 16'h7BDE};
        vecs[5] = '{valor: 16'h1234, habil: 4'hF, supr: 1'b0, num: 16'h1234, anp: 16'h7BDE};
        rst_e = '{num: 4'h0, an: 4'hF, blank: 1'b1, fin: 1'b0};

        repeat (3) @(negedge clk);
        check_out("reset_hold", rst_e);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            habil = vecs[k].habil;
            supr_ceros = vecs[k].supr;
            pulse(vecs[k].valor);
            wait_fin($sformatf("vec%0d_sync", k));
            check_frame($sformatf("vec%0d", k), vecs[k].num, vecs[k].anp, 1'b1, -1, '0, -1, '0);
        end

        // Strobe during slot 1 must not tear the frame being shown
        check_frame("tear_cur", 16'h1234, 16'h7BDE, 1'b1, 8, 16'hABCD, -1, '0);
        check_frame("tear_next", 16'hABCD, 16'h7BDE, 1'b1, -1, '0, -1, '0);

        // Pending 0x9999, then a strobe on the frame-end edge overrides it
        check_frame("simul_cur", 16'hABCD, 16'h7BDE, 1'b1, 0, 16'h9999, FRAME - 1, 16'h5678);
        check_frame("simul_next", 16'h5678, 16'h7BDE, 1'b1, -1, '0, -1, '0);
        check_frame("simul_keep", 16'h5678, 16'h7BDE, 1'b1, -1, '0, -1, '0);

        // Asynchronous reset at cycle 13 with an update pending
        pulse(16'h7777);
        repeat (12) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_out("reset_async", rst_e);
        @(negedge clk);
        @(negedge clk);
        check_out("reset_held", rst_e);
        rst_n = 1'b1;
        check_frame("after_rst", 16'h0000, 16'h7BDE, 1'b0, -1, '0, -1, '0);
        check_frame("after_rst2", 16'h0000, 16'h7BDE, 1'b1, -1, '0, -1, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

endmodule
